// File: rtl/ch0re_alu_core_pkg.sv
// Shared types for the ch0re execute-stage ALU: operand width, shift width and op encoding.
package ch0re_types;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_EQ   = 4'd0,
        ALU_NE   = 4'd1,
        ALU_LT   = 4'd2,
        ALU_GE   = 4'd3,
        ALU_LTU  = 4'd4,
        ALU_GEU  = 4'd5,
        ALU_ADD  = 4'd6,
        ALU_SUB  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_AND  = 4'd10,
        ALU_SLL  = 4'd11,
        ALU_SRL  = 4'd12,
        ALU_SRA  = 4'd13,
        ALU_SLT  = 4'd14,
        ALU_SLTU = 4'd15
    } alu_op_e;

    // Ops whose less-than flag uses an unsigned compare; everything else compares signed.
    function automatic logic is_unsigned_cmp(alu_op_e op);
        return (op == ALU_LTU) || (op == ALU_GEU) || (op == ALU_SLTU);
    endfunction

    // Ops that reuse the subtractor output as their result.
    function automatic logic is_sub_result(alu_op_e op);
        return (op == ALU_EQ) || (op == ALU_NE) || (op == ALU_LT) || (op == ALU_GE) ||
               (op == ALU_LTU) || (op == ALU_GEU) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/ch0re_alu_core_if.sv
// Signal bundle between the forwarding stage, the ALU and the branch unit.
interface ch0re_alu_intf;
    import ch0re_types::*;

    logic                i_clk;
    logic                i_rst_n;
    alu_op_e             i_op;
    logic [XLEN-1:0]     i_s1;
    logic [XLEN-1:0]     i_s2;
    logic [XLEN-1:0]     o_res;
    logic                o_flag_zero;
    logic                o_flag_less;

    modport master (
        output i_clk, i_rst_n, i_op, i_s1, i_s2,
        input  o_res, o_flag_zero, o_flag_less
    );

    modport slave (
        input  i_clk, i_rst_n, i_op, i_s1, i_s2,
        output o_res, o_flag_zero, o_flag_less
    );

endinterface

// File: rtl/ch0re_alu_core_shifter.sv
// Combinational log-depth barrel shifter shared by SLL, SRL and SRA.
// Left shifts reuse the right-shift stages by bit-reversing the operand before and after.
module ch0re_alu_shifter
    import ch0re_types::*;
(
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir_right,
    input  logic               arith,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] rev_in;
    logic [XLEN-1:0] rev_out;
    logic [XLEN-1:0] stage [SHAMT_W+1];
    logic            fill;

    // Sign fill only makes sense when shifting right.
    assign fill = arith & dir_right & operand[XLEN-1];

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
            assign rev_in[gi]  = operand[XLEN-1-gi];
            assign rev_out[gi] = stage[SHAMT_W][XLEN-1-gi];
        end
    endgenerate

    assign stage[0] = dir_right ? operand : rev_in;

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = shamt[gi] ? {{SH{fill}}, stage[gi][XLEN-1:SH]}
                                           : stage[gi];
        end
    endgenerate

    assign result = dir_right ? stage[SHAMT_W] : rev_out;

endmodule

// File: rtl/ch0re_alu_core.sv
// ch0re execute-stage integer ALU: RV64I arithmetic/logic/shift/slt plus branch-compare flags.
// Define CH0RE_ALU_COMB_OUT_EN to drop the output register (zero latency, clock/reset unused).
module ch0re_alu_core
    import ch0re_types::*;
(
    ch0re_alu_intf.slave bus
);

    alu_op_e         op;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] shift_res;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            shift_right;
    logic            shift_arith;

    logic [XLEN-1:0] res_d;
    logic            zero_d;
    logic            less_d;

    assign op  = bus.i_op;
    assign s1  = bus.i_s1;
    assign s2  = bus.i_s2;

    assign sum         = s1 + s2;
    assign diff        = s1 - s2;
    assign lt_signed   = $signed(s1) < $signed(s2);
    assign lt_unsigned = s1 < s2;

    assign shift_right = (op != ALU_SLL);
    assign shift_arith = (op == ALU_SRA);

    ch0re_alu_shifter u_shifter (
        .operand   (s1),
        .shamt     (s2[SHAMT_W-1:0]),
        .dir_right (shift_right),
        .arith     (shift_arith),
        .result    (shift_res)
    );

    always_comb begin
        res_d  = '0;
        zero_d = (s1 == s2);
        less_d = is_unsigned_cmp(op) ? lt_unsigned : lt_signed;

        if (is_sub_result(op)) begin
            res_d = diff;
        end else begin
            unique case (op)
                ALU_ADD:                   res_d = sum;
                ALU_OR:                    res_d = s1 | s2;
                ALU_XOR:                   res_d = s1 ^ s2;
                ALU_AND:                   res_d = s1 & s2;
                ALU_SLL, ALU_SRL, ALU_SRA: res_d = shift_res;
                ALU_SLT:                   res_d = {{(XLEN-1){1'b0}}, lt_signed};
                ALU_SLTU:                  res_d = {{(XLEN-1){1'b0}}, lt_unsigned};
                default:                   res_d = diff;
            endcase
        end
    end

`ifdef CH0RE_ALU_COMB_OUT_EN
    assign bus.o_res       = res_d;
    assign bus.o_flag_zero = zero_d;
    assign bus.o_flag_less = less_d;
`else
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            less_q;

    // Asynchronous clear so a result in flight when reset hits never reaches the branch unit.
    always_ff @(posedge bus.i_clk or negedge bus.i_rst_n) begin
        if (!bus.i_rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            less_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
            less_q <= less_d;
        end
    end

    assign bus.o_res       = res_q;
    assign bus.o_flag_zero = zero_q;
    assign bus.o_flag_less = less_q;
`endif

endmodule

// File: tb/tb_ch0re_alu_core.sv
// Randomised self-checking bench for ch0re_alu_core against a plain-arithmetic reference model.
// Works for both builds; with CH0RE_ALU_COMB_OUT_EN the expected latency is zero.
module tb_ch0re_alu_core;
    import ch0re_types::*;

`ifdef CH0RE_ALU_COMB_OUT_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        less;
    } exp_t;

    ch0re_alu_intf bus ();

    ch0re_alu_core dut (
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

    initial bus.i_clk = 1'b0;
    always #5 bus.i_clk = ~bus.i_clk;

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   sh;
        sh = int'(b[5:0]);
        case (op)
            4'd6:    e.res = a + b;
            4'd8:    e.res = a | b;
            4'd9:    e.res = a ^ b;
            4'd10:   e.res = a & b;
            4'd11:   e.res = a << sh;
            4'd12:   e.res = a >> sh;
            4'd13:   e.res = $unsigned($signed(a) >>> sh);
            4'd14:   e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd15:   e.res = (a < b) ? 64'd1 : 64'd0;
            default: e.res = a - b;
        endcase
        e.zero = (a == b);
        if (op == 4'd4 || op == 4'd5 || op == 4'd15) e.less = (a < b);
        else                                         e.less = ($signed(a) < $signed(b));
        return e;
    endfunction

    // Cycle-by-cycle compare: registered build sees last cycle's inputs, comb build the current ones.
    initial begin : compare
        exp_t cur, prev, expv;
        prev = '0;
        forever begin
            @(negedge bus.i_clk);
            cur = model(4'(bus.i_op), bus.i_s1, bus.i_s2);
            if (LAT == 0)          expv = cur;
            else if (!bus.i_rst_n) expv = '0;
            else                   expv = prev;
            prev = cur;
            checks++;
            if (bus.o_res !== expv.res || bus.o_flag_zero !== expv.zero || bus.o_flag_less !== expv.less) begin
                errors++;
                $display("FAIL cycle t=%0t res=%h zero=%b less=%b expected res=%h zero=%b less=%b",
                         $time, bus.o_res, bus.o_flag_zero, bus.o_flag_less, expv.res, expv.zero, expv.less);
            end else begin
                $display("ok   t=%0t op=%0d s1=%h s2=%h res=%h z=%b l=%b",
                         $time, 4'(bus.i_op), bus.i_s1, bus.i_s2, bus.o_res, bus.o_flag_zero, bus.o_flag_less);
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bus.i_op = alu_op_e'(op);
        bus.i_s1 = a;
        bus.i_s2 = b;
    endtask

    // Hand-computed literal expectation for one op.
    task automatic lit(input string name, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic ez, input logic el);
        @(posedge bus.i_clk);
        #1;
        drive(op, a, b);
        if (LAT != 0) @(posedge bus.i_clk);
        @(negedge bus.i_clk);
        #1;
        checks++;
        if (bus.o_res !== er || bus.o_flag_zero !== ez || bus.o_flag_less !== el) begin
            errors++;
            $display("FAIL %s got res=%h z=%b l=%b want res=%h z=%b l=%b",
                     name, bus.o_res, bus.o_flag_zero, bus.o_flag_less, er, ez, el);
        end else begin
            $display("lit  %s res=%h z=%b l=%b", name, bus.o_res, bus.o_flag_zero, bus.o_flag_less);
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = ALL_ONE;
            2:       v = MIN_INT;
            3:       v = 64'(64'h7FFF_FFFF_FFFF_FFFF);
            4:       v = 64'($urandom_range(0, 70));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] a, b;
        bus.i_rst_n = 1'b0;
        drive(4'd6, 64'd5, 64'd7);
        repeat (3) @(negedge bus.i_clk);
        #1;
        checks++;
        if (bus.o_res !== ((LAT != 0) ? 64'd0 : 64'd12)) begin
            errors++;
            $display("FAIL reset_hold got res=%h", bus.o_res);
        end
        bus.i_rst_n = 1'b1;
        @(posedge bus.i_clk);
        @(negedge bus.i_clk);
        #1;
        checks++;
        if (bus.o_res !== 64'd12) begin
            errors++;
            $display("FAIL reset_release got res=%h want %h", bus.o_res, 64'd12);
        end

        lit("add_wrap",  4'd6,  ALL_ONE, 64'd1, 64'd0, 1'b0, 1'b1);
        lit("sub_neg",   4'd7,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
        lit("sra",       4'd13, MIN_INT, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b1);
        lit("srl",       4'd12, MIN_INT, 64'h43, 64'h1000_0000_0000_0000, 1'b0, 1'b1);
        lit("sll63",     4'd11, 64'd1, 64'd63, MIN_INT, 1'b0, 1'b1);
        lit("sll0",      4'd11, 64'h1234, 64'h40, 64'h1234, 1'b0, 1'b0);
        lit("slt",       4'd14, ALL_ONE, 64'd1, 64'd1, 1'b0, 1'b1);
        lit("sltu",      4'd15, ALL_ONE, 64'd1, 64'd0, 1'b0, 1'b0);
        lit("and",       4'd10, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0);
        lit("or",        4'd8,  64'hF0, 64'h3C, 64'hFC, 1'b0, 1'b0);
        lit("xor",       4'd9,  64'hF0, 64'h3C, 64'hCC, 1'b0, 1'b0);
        lit("eq",        4'd0,  64'd42, 64'd42, 64'd0, 1'b1, 1'b0);
        lit("lt",        4'd2,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1);
        lit("ltu",       4'd4,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
        lit("geu",       4'd5,  64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 1'b0, 1'b1);
        lit("lt_min",    4'd2,  MIN_INT, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        lit("ltu_min",   4'd4,  MIN_INT, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        for (int op = 0; op < 16; op++) begin
            @(posedge bus.i_clk);
            #1;
            drive(4'(op), {$urandom, $urandom}, {$urandom, $urandom});
        end

        for (int i = 0; i < 250; i++) begin
            @(posedge bus.i_clk);
            #1;
            if (i == 120) begin
                bus.i_rst_n = 1'b0;
                @(negedge bus.i_clk);
                @(negedge bus.i_clk);
                #1;
                bus.i_rst_n = 1'b1;
            end else begin
                a = rand_operand();
                b = ($urandom_range(0, 9) == 0) ? a : rand_operand();
                drive(4'($urandom_range(0, 15)), a, b);
            end
        end

        repeat (2) @(posedge bus.i_clk);
        @(negedge bus.i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ch0re_alu_core.md
Name: ch0re_alu_core

Overview:
- Integer ALU for the ch0re pipeline execute stage.
- Performs RV64I add/sub/logic/shift/set-less-than and produces the branch-compare flags (zero, less) for EQ/NE/LT/GE/LTU/GEU.
- Operands come from the register-read/forwarding stage.
- All signals are bundled in interface ch0re_alu_intf; the module takes that interface as its only port.

Parameters:
- XLEN, 64, operand/result width.
- SHAMT_W, $clog2(XLEN) = 6, shift-amount width.

Ports:
- i_clk  input  1  clock; rising edge active.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_op  input  4  operation, type alu_op_e.
- i_s1  input  XLEN  source operand 1.
- i_s2  input  XLEN  source operand 2.
- o_res  output  XLEN  result.
- o_flag_zero  output  1  high when i_s1 == i_s2.
- o_flag_less  output  1  high when i_s1 < i_s2 (signedness per op).

Behaviour:
- Clocking and reset are decided: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- alu_op_e encoding (4 bits, all 16 codes legal): EQ=0, NE=1, LT=2, GE=3, LTU=4, GEU=5, ADD=6, SUB=7, OR=8, XOR=9, AND=10, SLL=11, SRL=12, SRA=13, SLT=14, SLTU=15.
- Datapath is combinational. Outputs are registered on the i_clk rising edge, so latency is 1 cycle. A new op is accepted every cycle with no handshake.
- Reset: o_res = 0, o_flag_zero = 0, o_flag_less = 0, asserted immediately and held while i_rst_n = 0. The first edge after release captures the current inputs.
- ADD, SUB: modulo 2^XLEN; carry/overflow discarded.
- OR, XOR, AND: bitwise.
- Shifts use shamt = i_s2[SHAMT_W-1:0]; upper bits of i_s2 are ignored.
  - SLL: logical left.
  - SRL: logical right, zero fill.
  - SRA: arithmetic right, sign fill from i_s1[XLEN-1].
- SLT: o_res = 1 if $signed(i_s1) < $signed(i_s2), else 0; zero-extended.
- SLTU: o_res = 1 if i_s1 < i_s2 unsigned, else 0; zero-extended.
- Compare ops (EQ/NE/LT/GE/LTU/GEU): o_res = i_s1 - i_s2. The branch unit uses only the flags.
- Flags are computed for every op:
  - o_flag_zero = (i_s1 == i_s2).
  - o_flag_less = unsigned compare for LTU, GEU, SLTU; signed compare for all other ops.
  - The ALU does not invert flags for NE/GE/GEU; the branch unit derives taken from the flags.
- Boundary cases:
  - shamt = 0 returns i_s1 unchanged.
  - shamt = 63 is legal.
  - i_s1 = i_s2 gives zero = 1, less = 0.
  - MIN_INT vs 1: signed less = 1, unsigned less = 0.
  - Reset asserted mid-stream discards the in-flight result.

Optional Feature:
- Macro CH0RE_ALU_COMB_OUT_EN.
- Defined: the output register is removed. o_res and flags follow the inputs combinationally with zero latency, and i_clk/i_rst_n are unused (left connected).
- Not defined: registered outputs with 1-cycle latency, as above.

Decomposition:
- Package ch0re_types holds alu_op_e, XLEN, and the SHAMT_W localparam.
- Interface ch0re_alu_intf declares i_clk, i_rst_n, i_op, i_s1, i_s2, o_res, o_flag_zero, o_flag_less.
- One natural sub-module: ch0re_alu_shifter.
  - Inputs: operand, shamt, direction, arithmetic bit.
  - Combinational barrel shifter.
  - Shared by SLL/SRL/SRA.

Test Plan:
- Reset: hold i_rst_n = 0 with ADD 5,7 applied -> outputs stay 0. Release; after one edge -> o_res = 12.
- Arithmetic: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> o_res = 0, zero = 0. SUB 3 - 5 -> o_res = 0xFFFF_FFFF_FFFF_FFFE.
- Shifts:
  - SRA 0x8000_0000_0000_0000 by i_s2 = 0x43 (shamt 3) -> 0xF000_0000_0000_0000.
  - SRL of the same operand -> 0x1000_0000_0000_0000.
  - SLL 1 by 63 -> 0x8000_0000_0000_0000.
- Set-less-than: SLT -1,1 -> o_res = 1. SLTU -1,1 -> o_res = 0. AND/OR/XOR 0xF0,0x3C -> 0x30 / 0xFC / 0xCC.
- Branch flags:
  - EQ 42,42 -> zero = 1, less = 0.
  - LT -2,3 -> zero = 0, less = 1.
  - LTU -2,3 -> less = 0.
  - GEU 3,-2 -> less = 1.
- Sweep all 16 ops once, then 250 random ops with random operands, each checked against a reference model one cycle later; repeat with CH0RE_ALU_COMB_OUT_EN defined and zero latency.
